// File: rtl/ysyx_25040109_dmem_resp_if.sv
// Load/store request and response bundle between a requester (master) and the data memory (slave).
// Loads use a request handshake plus a held response; stores complete in the accept cycle.
interface ysyx_25040109_dmem_resp_if;
    logic        dmem_rvalid;
    logic        dmem_rready;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic        dmem_rdata_valid;
    logic        dmem_rdata_ready;
    logic        dmem_wvalid;
    logic        dmem_wready;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [2:0]  dmem_wlen;

    modport master (
        output dmem_rvalid, dmem_raddr, dmem_rdata_ready,
        output dmem_wvalid, dmem_waddr, dmem_wdata, dmem_wlen,
        input  dmem_rready, dmem_rdata, dmem_rdata_valid, dmem_wready
    );

    modport slave (
        input  dmem_rvalid, dmem_raddr, dmem_rdata_ready,
        input  dmem_wvalid, dmem_waddr, dmem_wdata, dmem_wlen,
        output dmem_rready, dmem_rdata, dmem_rdata_valid, dmem_wready
    );
endinterface

// File: rtl/ysyx_25040109_dmem_resp.sv
// Word-array data memory: stores write in the accept edge, loads respond RD_LATENCY edges after accept.
// Only accepts requests in IDLE (store wins ties); the load response is held until dmem_rdata_ready.
module ysyx_25040109_dmem_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_25040109_dmem_resp_if.slave      bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] raddr_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        ld_acc, st_acc;
    logic [31:0] rd_addr, rd_off, rd_word, rd_data;
    logic        rd_hit;
    logic [31:0] wr_off, wr_dat;
    logic        wr_hit;
    logic [3:0]  wr_len_mask, wr_mask;

    assign bus.dmem_wready      = (state_q == IDLE);
    assign bus.dmem_rready      = (state_q == IDLE) && !bus.dmem_wvalid;
    assign bus.dmem_rdata       = rdata_q;
    assign bus.dmem_rdata_valid = rdata_valid_q;

    assign ld_acc = bus.dmem_rvalid && bus.dmem_rready;
    assign st_acc = bus.dmem_wvalid && bus.dmem_wready;

    // In IDLE the read port looks at the live address so RD_LATENCY=1 can sample on the accept edge.
    always_comb begin
        rd_addr = (state_q == IDLE) ? bus.dmem_raddr : raddr_q;
        rd_off  = rd_addr - BASE_ADDR;
        rd_hit  = (rd_addr >= BASE_ADDR) && ((rd_off >> 2) < 32'(DEPTH_WORDS));
        rd_word = rd_hit ? mem[rd_off[IDX_W+1:2]] : 32'h0;
        rd_data = rd_word >> {rd_addr[1:0], 3'b000};
    end

    always_comb begin
        wr_off = bus.dmem_waddr - BASE_ADDR;
        wr_hit = (bus.dmem_waddr >= BASE_ADDR) && ((wr_off >> 2) < 32'(DEPTH_WORDS));
        case (bus.dmem_wlen)
            3'b001:  wr_len_mask = 4'b0001;
            3'b010:  wr_len_mask = 4'b0011;
            3'b100:  wr_len_mask = 4'b1111;
            default: wr_len_mask = 4'b0000;
        endcase
        // 4-bit shift drops lanes past byte 3 instead of wrapping into the next word.
        wr_mask = wr_len_mask << bus.dmem_waddr[1:0];
        wr_dat  = bus.dmem_wdata << {bus.dmem_waddr[1:0], 3'b000};
    end

    always_ff @(posedge clk) begin
        if (st_acc && wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_off[IDX_W+1:2]][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            raddr_q       <= 32'h0;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_acc) begin
                        raddr_q <= bus.dmem_raddr;
                        if (RD_LATENCY == 1) begin
                            state_q       <= RESP;
                            rdata_q       <= rd_data;
                            rdata_valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(RD_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q       <= RESP;
                        rdata_q       <= rd_data;
                        rdata_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.dmem_rdata_ready) begin
                        state_q       <= IDLE;
                        rdata_q       <= 32'h0;
                        rdata_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_dmem_resp.sv
// Bench for ysyx_25040109_dmem_resp: directed scenarios plus random traffic against a byte-addressed model.
// Expected load data is queued at accept; an independent monitor pops and compares on each response.
module tb_ysyx_25040109_dmem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_25040109_dmem_resp_if bus ();

    ysyx_25040109_dmem_resp #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .RD_LATENCY  (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] dat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mdl [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nloads = 0;
    int          nresp = 0;
    int          stall_left = 0;
    int          last_vcnt = 0;
    logic [31:0] last_rdata = 32'h0;
    bit          rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // Reference model: memory as individual bytes at their byte addresses.
    function automatic bit in_mem(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(DEPTH) * 4);
    endfunction

    function automatic void mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
        int n;
        n = (l == 3'b001) ? 1 : (l == 3'b010) ? 2 : (l == 3'b100) ? 4 : 0;
        if (!in_mem(a)) return;
        for (int i = 0; i < n; i++) begin
            if (int'(a[1:0]) + i < 4) mdl[32'(a + i)] = d[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (!in_mem(a)) return 32'h0;
        for (int k = 0; int'(a[1:0]) + k < 4; k++) begin
            r[8*k +: 8] = mdl.exists(32'(a + k)) ? mdl[32'(a + k)] : 8'h00;
        end
        return r;
    endfunction

    task automatic drv_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        bus.dmem_wvalid = 1'b1;
        bus.dmem_waddr  = a;
        bus.dmem_wdata  = d;
        bus.dmem_wlen   = l;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.dmem_wready) got = 1'b1;
        end
        chk(got, "store_handshake", 32'(got), 32'h1);
        if (got) mdl_store(a, d, l);
        @(posedge clk); #1;
        bus.dmem_wvalid = 1'b0;
    endtask

    task automatic drv_load(input logic [31:0] a);
        bit   got;
        exp_t e;
        got = 1'b0;
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_raddr  = a;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.dmem_rready) got = 1'b1;
        end
        chk(got, "load_handshake", 32'(got), 32'h1);
        if (got) begin
            e.dat = mdl_load(a);
            e.acc = cyc;
            q.push_back(e);
            nloads++;
        end
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.dmem_rdata_valid) done = 1'b1;
        end
        chk(done, "drain", 32'(q.size()), 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int          s;
        int          w;
        logic [31:0] off;
        s   = $urandom_range(15);
        off = 32'($urandom_range(3));
        if (s == 0) begin
            case ($urandom_range(2))
                0:       return BASE - 32'd4 + off;
                1:       return BASE + 32'(DEPTH * 4) + off;
                default: return 32'h0000_0100 + off;
            endcase
        end
        w = $urandom_range(19);
        if (w >= 16) w = w + 1004;
        return BASE + 32'(w * 4) + off;
    endfunction

    function automatic logic [2:0] rand_len();
        logic [2:0] bad [5];
        int         r;
        bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        r = $urandom_range(9);
        if (r < 3) return 3'b001;
        if (r < 6) return 3'b010;
        if (r < 9) return 3'b100;
        return bad[$urandom_range(4)];
    endfunction

    // Response acceptor: random or forced-low stalls; stall cycles only count while a response is shown.
    initial begin
        bus.dmem_rdata_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                bus.dmem_rdata_ready = 1'b0;
                if (bus.dmem_rdata_valid) stall_left--;
            end else begin
                bus.dmem_rdata_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: checks latency, data, hold-stability and request blocking on every response cycle.
    initial begin
        bit          pend;
        logic [31:0] pend_data;
        int          vcnt;
        pend = 1'b0;
        pend_data = 32'h0;
        vcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                chk(bus.dmem_rdata_valid, "valid_hold", 32'(bus.dmem_rdata_valid), 32'h1);
                chk(bus.dmem_rdata == pend_data, "rdata_hold", bus.dmem_rdata, pend_data);
            end
            if (bus.dmem_rdata_valid) begin
                chk(!bus.dmem_wready && !bus.dmem_rready, "busy_ready",
                    {30'h0, bus.dmem_wready, bus.dmem_rready}, 32'h0);
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_resp", bus.dmem_rdata, 32'h0);
                end else begin
                    if (!pend) begin
                        chk(cyc - q[0].acc == LAT, "latency", 32'(cyc - q[0].acc), 32'(LAT));
                        vcnt = 0;
                    end
                    vcnt++;
                    chk(bus.dmem_rdata == q[0].dat, "rdata", bus.dmem_rdata, q[0].dat);
                    if (bus.dmem_rdata_ready) begin
                        void'(q.pop_front());
                        last_rdata = bus.dmem_rdata;
                        last_vcnt  = vcnt;
                        nresp++;
                        pend = 1'b0;
                    end else begin
                        pend      = 1'b1;
                        pend_data = bus.dmem_rdata;
                    end
                end
            end else begin
                pend = 1'b0;
                chk(bus.dmem_rdata == 32'h0, "rdata_idle", bus.dmem_rdata, 32'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dmem_rvalid = 1'b0;
        bus.dmem_raddr  = 32'h0;
        bus.dmem_wvalid = 1'b0;
        bus.dmem_waddr  = 32'h0;
        bus.dmem_wdata  = 32'h0;
        bus.dmem_wlen   = 3'b000;

        repeat (2) @(negedge clk);
        chk(bus.dmem_rdata_valid == 1'b0, "rst_valid", 32'(bus.dmem_rdata_valid), 32'h0);
        chk(bus.dmem_rdata == 32'h0, "rst_rdata", bus.dmem_rdata, 32'h0);
        chk(bus.dmem_wready == 1'b1, "rst_wready", 32'(bus.dmem_wready), 32'h1);
        chk(bus.dmem_rready == 1'b1, "rst_rready", 32'(bus.dmem_rready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int w = 0; w < 20; w++) begin
            drv_store(BASE + 32'(((w < 16) ? w : w + 1004) * 4), $urandom, 3'b100);
        end

        drv_store(32'h8000_0010, 32'hDEAD_BEEF, 3'b100);
        drv_load(32'h8000_0010);
        wait_drain();
        chk(last_rdata == 32'hDEAD_BEEF, "sw_lw", last_rdata, 32'hDEAD_BEEF);

        drv_store(32'h8000_0010, 32'h1122_3344, 3'b100);
        drv_store(32'h8000_0013, 32'h0000_00A5, 3'b001);
        drv_load(32'h8000_0010);
        wait_drain();
        chk(last_rdata == 32'hA522_3344, "sb_word", last_rdata, 32'hA522_3344);
        drv_load(32'h8000_0013);
        wait_drain();
        chk(last_rdata == 32'h0000_00A5, "sb_byte", last_rdata, 32'h0000_00A5);

        stall_left = 3;
        drv_load(32'h8000_0010);
        wait_drain();
        chk(last_vcnt == 4, "stall_valid_cycles", 32'(last_vcnt), 32'h4);

        @(posedge clk); #1;
        bus.dmem_wvalid = 1'b1;
        bus.dmem_waddr  = 32'h8000_0024;
        bus.dmem_wdata  = 32'hCAFE_F00D;
        bus.dmem_wlen   = 3'b100;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_raddr  = 32'h8000_0024;
        @(negedge clk);
        chk(bus.dmem_wready == 1'b1, "tie_wready", 32'(bus.dmem_wready), 32'h1);
        chk(bus.dmem_rready == 1'b0, "tie_rready", 32'(bus.dmem_rready), 32'h0);
        mdl_store(32'h8000_0024, 32'hCAFE_F00D, 3'b100);
        @(posedge clk); #1;
        bus.dmem_wvalid = 1'b0;
        @(negedge clk);
        chk(bus.dmem_rready == 1'b1, "tie_load_next", 32'(bus.dmem_rready), 32'h1);
        begin
            exp_t e;
            e.dat = mdl_load(32'h8000_0024);
            e.acc = cyc;
            q.push_back(e);
            nloads++;
        end
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0;
        wait_drain();
        chk(last_rdata == 32'hCAFE_F00D, "tie_load_data", last_rdata, 32'hCAFE_F00D);

        drv_load(32'h7FFF_FFFC);
        wait_drain();
        chk(last_rdata == 32'h0, "oor_load", last_rdata, 32'h0);
        drv_store(32'h8000_0020, 32'h5A5A_1234, 3'b100);
        drv_store(32'h8000_0020, 32'hFFFF_FFFF, 3'b011);
        drv_store(32'h7FFF_FFFC, 32'hFFFF_FFFF, 3'b100);
        drv_load(32'h8000_0020);
        wait_drain();
        chk(last_rdata == 32'h5A5A_1234, "bad_len_nowrite", last_rdata, 32'h5A5A_1234);

        drv_load(32'h8000_0010);
        rst = 1'b0;
        q.delete();
        nloads--;
        repeat (3) begin
            @(negedge clk);
            chk(bus.dmem_rdata_valid == 1'b0, "inrst_valid", 32'(bus.dmem_rdata_valid), 32'h0);
            chk(bus.dmem_rdata == 32'h0, "inrst_rdata", bus.dmem_rdata, 32'h0);
            chk(bus.dmem_wready == 1'b1, "inrst_wready", 32'(bus.dmem_wready), 32'h1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk(bus.dmem_rdata_valid == 1'b0, "post_rst_valid", 32'(bus.dmem_rdata_valid), 32'h0);
        end
        chk(bus.dmem_rready == 1'b1, "post_rst_idle", 32'(bus.dmem_rready), 32'h1);
        drv_load(32'h8000_0010);
        wait_drain();
        chk(last_rdata == 32'hA522_3344, "post_rst_data", last_rdata, 32'hA522_3344);

        rand_ready = 1'b1;
        repeat (250) begin
            if ($urandom_range(1) == 0) drv_store(rand_addr(), $urandom, rand_len());
            else                        drv_load(rand_addr());
        end
        wait_drain();
        rand_ready = 1'b0;

        chk(q.size() == 0, "queue_empty", 32'(q.size()), 32'h0);
        chk(nresp == nloads, "resp_count", 32'(nresp), 32'(nloads));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
